prog_loader: RTL and testbench

//  Writer side of the instruction-memory interface. Receives a program as 5-bit

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 39 +++
 rtl/prog_loader_nibble_packer.sv | 45 ++++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader
//
// Purpose : command codes, nibble width and FSM state type shared by the
//           loader top and its nibble packer.
// Ports   : none (package)
package loader_pkg;

   localparam int NIB_W = 4;

   localparam logic [NIB_W-1:0] CMD_RESET_ADDR = 4'h0;
   localparam logic [NIB_W-1:0] CMD_START      = 4'h1;
   localparam logic [NIB_W-1:0] CMD_HALT       = 4'h2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      RUN   = 2'd3
   } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - symbol stream, instr-memory write port and cpu control bundle
//
// Purpose : groups every non-clock signal of the loader.
// Ports   : din/din_valid/din_ready  symbol stream into the loader
//           imem_addr/data/wren      instr-memory write port
//           cpu_resetn/run/done      processor control and Done pulse
//           words_loaded/overflow/instr_count  status
// Modports: master = loader side, slave = environment side.
interface prog_loader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);

   logic [4:0]        din;
   logic              din_valid;
   logic              din_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              imem_wren;
   logic              cpu_resetn;
   logic              cpu_run;
   logic              cpu_done;
   logic [ADDR_W:0]   words_loaded;
   logic              overflow;
   logic [15:0]       instr_count;

   modport master (
      input  din, din_valid, cpu_done,
      output din_ready, imem_addr, imem_data, imem_wren,
             cpu_resetn, cpu_run, words_loaded, overflow, instr_count
   );

   modport slave (
      output din, din_valid, cpu_done,
      input  din_ready, imem_addr, imem_data, imem_wren,
             cpu_resetn, cpu_run, words_loaded, overflow, instr_count
   );

endinterface

// File: rtl/prog_loader_nibble_packer.sv
// rtl/prog_loader_nibble_packer.sv - MSB-first nibble shift register with word count
//
// Purpose : assembles DATA_W/4 nibbles into one word.
// Ports   : Clock, Resetn  clock, async active-low reset
//           clear          drop any partial word (wins over shift_en)
//           shift_en, nib  shift nib into the low end
//           word           assembled word register
//           word_ready     this shift completes a word (combinational)
module nibble_packer
   import loader_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [NIB_W-1:0]  nib,
   output logic [DATA_W-1:0] word,
   output logic              word_ready
);

   localparam int NIB_CNT = DATA_W / NIB_W;
   localparam int CNT_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB_CNT - 1);

   logic [CNT_W-1:0] cnt;

   assign word_ready = shift_en && (cnt == CNT_LAST);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cnt  <= '0;
         word <= '0;
      end else if (clear) begin
         cnt  <= '0;
         word <= '0;
      end else if (shift_en) begin
         word <= {word[DATA_W-NIB_W-1:0], nib};
         // Count returns to zero on the last nibble so IDLE always sees an empty packer.
         cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - instr-memory loader: packs nibbles, writes words, controls cpu
//
// Purpose : receives 5-bit symbols (data nibbles or commands), writes packed
//           16-bit words to consecutive instr-memory addresses, then releases
//           the processor and counts its Done pulses.
// Ports   : Clock   single clock, rising edge
//           Resetn  asynchronous active-low reset
//           bus     prog_loader_if.master (stream, imem write, cpu control, status)
module prog_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic          Clock,
   input  logic          Resetn,
   prog_loader_if.master bus
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   state_t            state;
   logic              din_ready_r;
   logic              wren_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   words_r;
   logic              ovf_r;
   logic              cpu_resetn_r;
   logic              cpu_run_r;
   logic [15:0]       icount_r;

   logic              accept;
   logic              is_cmd;
   logic [NIB_W-1:0]  code;
   logic              known_cmd;
   logic              shift_en;
   logic              clear;
   logic              word_ready;
   logic [DATA_W-1:0] word;

   assign accept    = bus.din_valid && din_ready_r;
   assign is_cmd    = bus.din[4];
   assign code      = bus.din[3:0];
   assign known_cmd = (code == CMD_RESET_ADDR) || (code == CMD_START) || (code == CMD_HALT);

   // Data only assembles outside RUN; every known command leaving LOAD discards the partial word.
   assign shift_en = accept && !is_cmd && ((state == IDLE) || (state == LOAD));
   assign clear    = accept && is_cmd && known_cmd && (state == LOAD);

   nibble_packer #(.DATA_W(DATA_W)) u_packer (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .clear      (clear),
      .shift_en   (shift_en),
      .nib        (code),
      .word       (word),
      .word_ready (word_ready)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state        <= IDLE;
         din_ready_r  <= 1'b1;
         wren_r       <= 1'b0;
         addr_r       <= '0;
         words_r      <= '0;
         ovf_r        <= 1'b0;
         cpu_resetn_r <= 1'b0;
         cpu_run_r    <= 1'b0;
         icount_r     <= '0;
      end else begin
         wren_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (!is_cmd) begin
                     state <= LOAD;
                  end else if (code == CMD_RESET_ADDR) begin
                     addr_r  <= '0;
                     words_r <= '0;
                     ovf_r   <= 1'b0;
                  end else if (code == CMD_START) begin
                     state        <= RUN;
                     cpu_resetn_r <= 1'b1;
                     cpu_run_r    <= 1'b1;
                     icount_r     <= '0;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  if (!is_cmd) begin
                     if (word_ready) begin
                        // The write strobe is registered here so it lines up with the WRITE cycle.
                        state       <= WRITE;
                        din_ready_r <= 1'b0;
                        wren_r      <= !ovf_r;
                     end
                  end else if (code == CMD_RESET_ADDR) begin
                     state   <= IDLE;
                     addr_r  <= '0;
                     words_r <= '0;
                     ovf_r   <= 1'b0;
                  end else if (code == CMD_START) begin
                     state        <= RUN;
                     cpu_resetn_r <= 1'b1;
                     cpu_run_r    <= 1'b1;
                     icount_r     <= '0;
                  end else if (code == CMD_HALT) begin
                     state <= IDLE;
                  end
               end
            end
            WRITE: begin
               state       <= IDLE;
               din_ready_r <= 1'b1;
               if (!ovf_r) begin
                  words_r <= words_r + 1'b1;
                  addr_r  <= addr_r + 1'b1;
                  if (addr_r == ADDR_LAST) begin
                     ovf_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.cpu_done) begin
                  icount_r <= icount_r + 1'b1;
               end
               if (accept && is_cmd) begin
                  if (code == CMD_START) begin
                     icount_r <= '0;
                  end else if (code == CMD_HALT) begin
                     state        <= IDLE;
                     cpu_resetn_r <= 1'b0;
                     cpu_run_r    <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.din_ready    = din_ready_r;
   assign bus.imem_wren    = wren_r;
   assign bus.imem_addr    = addr_r;
   assign bus.imem_data    = word;
   assign bus.words_loaded = words_r;
   assign bus.overflow     = ovf_r;
   assign bus.cpu_resetn   = cpu_resetn_r;
   assign bus.cpu_run      = cpu_run_r;
   assign bus.instr_count  = icount_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;

   always #5 Clock = ~Clock;

   prog_loader_if #(.ADDR_W(5), .DATA_W(16)) bus ();

   prog_loader #(.ADDR_W(5), .DATA_W(16)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [4:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  asserts = 0;
   int  fails = 0;
   int  wren_cnt = 0;
   int  ready_low_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe is matched against the next expected write.
   always @(negedge Clock) begin
      if (Resetn === 1'b1) begin
         if (bus.din_ready !== 1'b1) ready_low_cnt++;
         if (bus.imem_wren === 1'b1) begin
            wr_t e;
            wren_cnt++;
            if (exp_q.size() == 0) begin
               asserts++;
               fails++;
               $display("FAIL unexpected_wren: addr %0h data %0h with nothing expected",
                        bus.imem_addr, bus.imem_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(bus.imem_addr), 32'(e.a));
               check("wr_data", 32'(bus.imem_data), 32'(e.d));
            end
         end
      end
   end

   task automatic send(input logic [4:0] s);
      int n = 0;
      bus.din       = s;
      bus.din_valid = 1'b1;
      while (bus.din_ready !== 1'b1 && n < 20) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 20) begin
         check("send_timeout", 32'(n), 32'd0);
      end
      @(posedge Clock);
      #1;
      bus.din_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send({1'b0, w[15:12]});
      send({1'b0, w[11:8]});
      send({1'b0, w[7:4]});
      send({1'b0, w[3:0]});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic pulse_done();
      @(posedge Clock);
      #1 bus.cpu_done = 1'b1;
      @(posedge Clock);
      #1 bus.cpu_done = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cpu_resetn"}, 32'(bus.cpu_resetn), 32'd0);
      check({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'd0);
      check({tag, "_wren"}, 32'(bus.imem_wren), 32'd0);
      check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
      check({tag, "_data"}, 32'(bus.imem_data), 32'd0);
      check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
      check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
      check({tag, "_icount"}, 32'(bus.instr_count), 32'd0);
      check({tag, "_ready"}, 32'(bus.din_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_rdy;
      int base_wr;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.cpu_done  = 1'b0;

      // 1: reset, one word, START
      cycles(3);
      check_reset_values("rst");
      Resetn = 1'b1;
      cycles(1);
      exp_q.push_back('{5'd0, 16'h2005});
      send_word(16'h2005);
      cycles(1);
      check("t1_run_before_start", 32'(bus.cpu_run), 32'd0);
      send(5'h11);
      check("t1_cpu_run", 32'(bus.cpu_run), 32'd1);
      check("t1_cpu_resetn", 32'(bus.cpu_resetn), 32'd1);
      check("t1_words", 32'(bus.words_loaded), 32'd1);
      check("t1_wren_cnt", 32'(wren_cnt), 32'd1);

      // 2: three words back-to-back
      send(5'h12);
      cycles(1);
      check("t2_halt_run", 32'(bus.cpu_run), 32'd0);
      send(5'h10);
      base_rdy = ready_low_cnt;
      exp_q.push_back('{5'd0, 16'h1111});
      exp_q.push_back('{5'd1, 16'h2222});
      exp_q.push_back('{5'd2, 16'h3333});
      send_word(16'h1111);
      send_word(16'h2222);
      send_word(16'h3333);
      cycles(3);
      check("t2_ready_low_cycles", 32'(ready_low_cnt - base_rdy), 32'd3);
      check("t2_addr", 32'(bus.imem_addr), 32'd3);
      check("t2_words", 32'(bus.words_loaded), 32'd3);

      // 3: fill memory, overflow, RESET_ADDR
      send(5'h10);
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back('{5'(i), 16'hA000 + 16'(i)});
         send_word(16'hA000 + 16'(i));
      end
      cycles(2);
      check("t3_ovf", 32'(bus.overflow), 32'd1);
      check("t3_addr_wrap", 32'(bus.imem_addr), 32'd0);
      check("t3_words", 32'(bus.words_loaded), 32'd32);
      base_wr = wren_cnt;
      send_word(16'hBEEF);
      cycles(2);
      check("t3_no_wren", 32'(wren_cnt - base_wr), 32'd0);
      check("t3_words_hold", 32'(bus.words_loaded), 32'd32);
      send(5'h10);
      check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
      check("t3_words_clr", 32'(bus.words_loaded), 32'd0);

      // 4: partial word discarded by START, HALT, fresh word
      base_wr = wren_cnt;
      send(5'h01);
      send(5'h02);
      send(5'h11);
      cycles(2);
      check("t4_no_wren", 32'(wren_cnt - base_wr), 32'd0);
      check("t4_run", 32'(bus.cpu_run), 32'd1);
      send(5'h12);
      check("t4_halt_run", 32'(bus.cpu_run), 32'd0);
      check("t4_halt_resetn", 32'(bus.cpu_resetn), 32'd0);
      exp_q.push_back('{5'd0, 16'h4567});
      send_word(16'h4567);
      cycles(2);
      check("t4_addr", 32'(bus.imem_addr), 32'd1);

      // 5: Done counting in RUN, dropped data/RESET_ADDR, second START
      send(5'h11);
      base_wr = wren_cnt;
      repeat (5) pulse_done();
      send(5'h03);
      send(5'h10);
      cycles(2);
      check("t5_icount", 32'(bus.instr_count), 32'd5);
      check("t5_no_wren", 32'(wren_cnt - base_wr), 32'd0);
      check("t5_addr", 32'(bus.imem_addr), 32'd1);
      check("t5_words", 32'(bus.words_loaded), 32'd1);
      send(5'h11);
      check("t5_icount_clr", 32'(bus.instr_count), 32'd0);
      send(5'h12);
      pulse_done();
      cycles(1);
      check("t5_done_outside_run", 32'(bus.instr_count), 32'd0);

      // 6: reset during WRITE
      send_word(16'h89AB);
      check("t6_wren_in_write", 32'(bus.imem_wren), 32'd1);
      Resetn = 1'b0;
      #1;
      check_reset_values("t6");
      @(negedge Clock);
      Resetn = 1'b1;
      cycles(1);
      exp_q.push_back('{5'd0, 16'hCDEF});
      send_word(16'hCDEF);
      cycles(3);
      check("t6_addr_after", 32'(bus.imem_addr), 32'd1);
      check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
